exponent_rescale_stream: RTL
============================

# exponent_rescale_stream

Streaming, frame-based successor to the combinational per-element exponent adjust in the FFT block-floating-point path. Buffers one frame of LANES-wide exponent beats and tracks the frame's maximum nonzero exponent. It then replays the frame with every nonzero exponent rebased, either by an external shift (bias-relative add) or normalised to the frame maximum. Zero exponents stay zero, underflow flushes to zero, overflow saturates. Sits between the butterfly output stage and the twiddle/mantissa realignment stage.

## Interface
- EXP_WIDTH, 4, exponent bits per element
- LANES, 8, elements per beat
- BEATS, 8, maximum beats per frame (default frame = 64 elements)
- BIAS, 8, constant subtracted in shift mode
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- mode  in  1  0 = shift mode, 1 = normalise mode; sampled with first accepted beat of a frame
- shift_exp  in  EXP_WIDTH  unsigned shift for mode 0; sampled with first accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts input beat
- in_exp  in  LANES*EXP_WIDTH  packed exponents, lane i at [i*EXP_WIDTH +: EXP_WIDTH]
- in_last  in  1  final beat of frame (optional before BEATS)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_exp  out  LANES*EXP_WIDTH  rescaled exponents, same packing
- out_last  out  1  final beat of frame
- out_frame_max  out  EXP_WIDTH  max nonzero exponent of the frame being drained (0 if all zero)

## Operation
- Two states: FILL, DRAIN. Reset state FILL.
- FILL: in_ready=1, out_valid=0. On each handshake (in_valid & in_ready): write beat to buffer[wr_cnt], wr_cnt++, update running max over all nonzero lanes. First beat of frame (wr_cnt==0) also latches mode and shift_exp, and restarts the running max from that beat's lanes.
- FILL->DRAIN: on the handshake of a beat with in_last=1 or wr_cnt==BEATS-1. Frame length k = beats accepted (1..BEATS). Latch k and the final max into out_frame_max.
- DRAIN: in_ready=0, out_valid=1, data from buffer[rd_cnt]. rd_cnt++ on out_valid & out_ready. out_last=1 when rd_cnt==k-1.
- DRAIN->FILL: on the handshake of the out_last beat. rd_cnt, wr_cnt cleared.
- Per-lane arithmetic, signed, EXP_WIDTH+2 bits, MAX=2^EXP_WIDTH-1:
  - e==0 -> 0 in both modes.
  - mode 0: t = e + shift - BIAS. t<=0 -> 0; t>MAX -> MAX; else t.
  - mode 1: t = e + MAX - frame_max. Range is 1..MAX by construction; the max element maps to MAX.
- in_last is ignored in DRAIN because in_ready=0 there. An in_last on the BEATS-th beat is consistent: the frame closes once.
- No mid-frame mode or shift changes take effect. The values latched on beat 0 hold until the next frame's beat 0.

## Timing
- Reset, rst_n low at a clk edge: state FILL, wr_cnt=rd_cnt=0, in_ready=0 while rst_n low, out_valid=0, out_last=0, out_exp=0, out_frame_max=0. in_ready=1 the first cycle after rst_n returns high.
- Reset mid-frame (FILL or DRAIN): partial frame discarded, no further output beats from it.
- First output beat is valid the cycle after the closing input handshake.
- out_exp is a combinational function of registered buffer entry, latched mode/shift and out_frame_max. It is forced to 0 when out_valid=0.
- Under backpressure (out_valid & !out_ready), out_exp, out_last and out_frame_max are held stable.
- Throughput: k-beat frame occupies k FILL cycles plus k DRAIN cycles with no stalls. Next frame's first beat is accepted the cycle after the out_last handshake.
- out_frame_max is valid throughout DRAIN and retains its value in the following FILL until the next frame closes.

## Test plan
- Mode 0, shift=10, BIAS=8, one beat lanes {0,3,7,15,...} with in_last -> out lanes {0,5,9,15}; 15+2=17 saturates to 15; out_last=1 on that beat.
- Mode 0, shift=2, lanes {3,7,0,6} -> {0,1,0,0}: 3-6 and 6-6 flush to 0, 7-6=1.
- Mode 1, 8-beat frame, max nonzero 12, lanes {12,5,1,0} -> {15,8,4,0}; out_frame_max=12; all-zero frame -> all-zero output, out_frame_max=0.
- Short frame with BEATS=8: in_last on 3rd beat -> exactly 3 output beats in order, out_last on 3rd. in_ready low from the cycle after the 3rd input handshake until the cycle after the 3rd output handshake.
- Random out_ready (about 50%) over 4 back-to-back frames with alternating mode -> no beat lost or duplicated, held outputs stable while stalled, each frame uses its own latched mode/shift.
- rst_n pulled low for 1 cycle during the 2nd DRAIN beat -> out_valid=0 next cycle, in_ready=1 the cycle after release, following frame output bit-exact.

Source files
------------

// File: rtl/exponent_rescale_stream_if.sv
// Stream bundle for exponent_rescale_stream: input beat channel with frame-level
// mode/shift sideband, and the rescaled output beat channel.
interface exponent_rescale_stream_if #(
  parameter int EXP_WIDTH = 4,
  parameter int LANES     = 8
);
  logic                       mode;
  logic [EXP_WIDTH-1:0]       shift_exp;
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*EXP_WIDTH-1:0] in_exp;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*EXP_WIDTH-1:0] out_exp;
  logic                       out_last;
  logic [EXP_WIDTH-1:0]       out_frame_max;

  modport master (
    output mode, shift_exp, in_valid, in_exp, in_last, out_ready,
    input  in_ready, out_valid, out_exp, out_last, out_frame_max
  );

  modport slave (
    input  mode, shift_exp, in_valid, in_exp, in_last, out_ready,
    output in_ready, out_valid, out_exp, out_last, out_frame_max
  );
endinterface

// File: rtl/exponent_rescale_stream.sv
// Frame-buffered exponent rescaler: fills one frame while tracking its max nonzero
// exponent, then replays it rebased by an external shift or normalised to that max.
module exponent_rescale_stream #(
  parameter int EXP_WIDTH = 4,
  parameter int LANES     = 8,
  parameter int BEATS     = 8,
  parameter int BIAS      = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  exponent_rescale_stream_if.slave  bus
);

  localparam int CW  = $clog2(BEATS + 1);
  localparam int IW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam int DW  = LANES * EXP_WIDTH;

  localparam logic [EXP_WIDTH-1:0] MAX_E  = '1;
  localparam logic signed [EW2-1:0] MAX_S  = EW2'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]        last_idx_q, last_idx_d;
  logic                 mode_q, mode_d;
  logic [EXP_WIDTH-1:0] shift_q, shift_d;
  logic [EXP_WIDTH-1:0] run_max_q, run_max_d;
  logic [EXP_WIDTH-1:0] frame_max_q, frame_max_d;

  logic [DW-1:0]        buf_q [BEATS];
  logic [DW-1:0]        rd_beat;
  logic [EXP_WIDTH-1:0] beat_max;
  logic                 in_hs;
  logic                 out_hs;
  logic                 first_beat;

  function automatic logic [EXP_WIDTH-1:0] max_e(input logic [EXP_WIDTH-1:0] a,
                                                 input logic [EXP_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Intermediate is EXP_WIDTH+2 bits signed so both underflow and overflow are visible.
  function automatic logic [EXP_WIDTH-1:0] rescale(input logic [EXP_WIDTH-1:0] e,
                                                   input logic                 md,
                                                   input logic [EXP_WIDTH-1:0] sh,
                                                   input logic [EXP_WIDTH-1:0] fm);
    logic signed [EW2-1:0] t;
    if (e == '0) return '0;
    if (md) t = $signed({2'b00, e}) + MAX_S - $signed({2'b00, fm});
    else    t = $signed({2'b00, e}) + $signed({2'b00, sh}) - BIAS_S;
    if (t <= 0)     return '0;
    if (t > MAX_S)  return MAX_E;
    return t[EXP_WIDTH-1:0];
  endfunction

  always_comb begin
    beat_max = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      beat_max = max_e(beat_max, bus.in_exp[l*EXP_WIDTH +: EXP_WIDTH]);
    end
  end

  assign in_hs      = bus.in_valid & in_ready_q;
  assign out_hs     = out_valid_q & bus.out_ready;
  assign first_beat = (wr_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    last_idx_d  = last_idx_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    run_max_d   = run_max_q;
    frame_max_d = frame_max_q;

    case (state_q)
      FILL: begin
        // in_ready is held low during reset; it rises on the first edge out of reset.
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (in_hs) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (first_beat) begin
            mode_d    = bus.mode;
            shift_d   = bus.shift_exp;
            run_max_d = beat_max;
          end else begin
            run_max_d = max_e(run_max_q, beat_max);
          end
          if (bus.in_last || (wr_cnt_q == CW'(BEATS - 1))) begin
            state_d     = DRAIN;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_last_d  = first_beat;
            last_idx_d  = wr_cnt_q;
            rd_cnt_d    = '0;
            frame_max_d = run_max_d;
          end
        end
      end
      DRAIN: begin
        in_ready_d = 1'b0;
        if (out_hs) begin
          if (out_last_q) begin
            state_d     = FILL;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_cnt_d    = '0;
            wr_cnt_d    = '0;
          end else begin
            rd_cnt_d   = rd_cnt_q + CW'(1);
            out_last_d = ((rd_cnt_q + CW'(1)) == last_idx_q);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      last_idx_q  <= '0;
      mode_q      <= 1'b0;
      shift_q     <= '0;
      run_max_q   <= '0;
      frame_max_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      last_idx_q  <= last_idx_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      run_max_q   <= run_max_d;
      frame_max_q <= frame_max_d;
    end
  end

  // Frame storage carries no reset; stale entries are never replayed.
  always_ff @(posedge clk) begin
    if (in_hs) buf_q[wr_cnt_q[IW-1:0]] <= bus.in_exp;
  end

  assign rd_beat = buf_q[rd_cnt_q[IW-1:0]];

  always_comb begin
    bus.out_exp = '0;
    if (out_valid_q) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        bus.out_exp[l*EXP_WIDTH +: EXP_WIDTH] =
          rescale(rd_beat[l*EXP_WIDTH +: EXP_WIDTH], mode_q, shift_q, frame_max_q);
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_frame_max = frame_max_q;

endmodule
